// File: rtl/keypad_pkg.sv
// Shared types and widths for the keypad debouncer.
package keypad_pkg;

  localparam int KEY_W                   = 4;
  localparam int KEY_CODE_W              = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_e;

endpackage

// File: rtl/keypad_debounce_if.sv
// Key bundle: raw levels in, debounced level, press strobe and key index out.
// key_valid is a one-cycle strobe with no ready: the consumer must sample
// key_code in the cycle key_valid is high; there is no back-pressure.
interface keypad_debounce_if;
  logic [keypad_pkg::KEY_W-1:0]      key_raw;
  logic [keypad_pkg::KEY_W-1:0]      key_out;
  logic                              key_valid;
  logic [keypad_pkg::KEY_CODE_W-1:0] key_code;

  modport master (output key_raw, input key_out, key_valid, key_code);
  modport slave  (input key_raw, output key_out, key_valid, key_code);
endinterface

// File: rtl/keypad_debounce_sync2.sv
// Per-bit two-flop synchronizer for asynchronous button levels.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// Four-button debouncer: accepts a single one-hot key after a stable window,
// emits a press strobe with the key index, and debounces the release too.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_W-1:0]      key_raw,
  output logic [KEY_W-1:0]      key_out,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output state_e                state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [KEY_W-1:0]  cand;
  logic [KEY_W-1:0]  key_sync;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  function automatic logic [KEY_CODE_W-1:0] encode(input logic [KEY_W-1:0] v);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < KEY_W; i++)
      if (v[i]) code = KEY_CODE_W'(i);
    return code;
  endfunction

  sync2 #(.W(KEY_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_raw),
    .q     (key_sync)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_out   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Zero or multi-hot input never starts a debounce.
          if (is_onehot(key_sync)) begin
            cand  <= key_sync;
            cnt   <= '0;
            state <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (key_sync != cand) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            key_out   <= cand;
            key_code  <= encode(cand);
            key_valid <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (key_sync != cand) begin
            cnt   <= '0;
            state <= DB_REL;
          end
        end
        DB_REL: begin
          // A glitch that returns to the held key resumes HELD silently.
          if (key_sync == cand) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            key_out <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_debounce.md
KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable synchronized cycles required to accept a press or release (>= 2; benches use 4).
REQ-002 SHALL have parameter CNT_W, default ceil(log2(DEBOUNCE_CYCLES)), giving the debounce counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all flops are rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key_raw, input, 4 bits: raw asynchronous push-button levels, 1 = pressed.
REQ-006 SHALL have port key_out, output, 4 bits: debounced one-hot key level, which drives key_in of keypad_map_top.
REQ-007 SHALL have port key_valid, output, 1 bit: single-cycle strobe on each accepted press.
REQ-008 SHALL have port key_code, output, 2 bits: binary index of the accepted key (0001->0, 0010->1, 0100->2, 1000->3).

Function
REQ-009 SHALL pass key_raw through a 2-flop synchronizer (key_sync), adding 2 edges of latency.
REQ-010 SHALL implement FSM states IDLE, DB_PRESS, HELD, DB_REL.
REQ-011 In IDLE, if key_sync is exactly one-hot, the FSM SHALL latch cand<=key_sync, set cnt<=0 and go to DB_PRESS; otherwise (zero or multi-hot) it SHALL stay in IDLE.
REQ-012 In DB_PRESS, if key_sync!=cand the FSM SHALL return to IDLE with cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 it SHALL go to HELD; else cnt<=cnt+1.
REQ-013 On the DB_PRESS->HELD edge, the block SHALL set key_out<=cand and key_code<=encode(cand), and assert key_valid for exactly that one following cycle.
REQ-014 In HELD, if key_sync!=cand (release, different key, or added key) the FSM SHALL go to DB_REL with cnt<=0.
REQ-015 In DB_REL, if key_sync==cand the FSM SHALL return to HELD with no new strobe; else if cnt==DEBOUNCE_CYCLES-1 it SHALL go to IDLE with key_out<=0; else cnt<=cnt+1.
REQ-016 Press latency SHALL be exact: key_raw stable one-hot from edge 0 gives key_out valid after edge DEBOUNCE_CYCLES+3; release latency SHALL be identical.
REQ-017 A direct key change A->B SHALL produce key_out A -> 0000 (release path) -> B, with B appearing DEBOUNCE_CYCLES+1 edges after 0000.
REQ-018 key_out SHALL always be 0000 or exactly one-hot, and SHALL change only on FSM transitions.
REQ-019 key_code SHALL hold its last value while key_out=0000.
REQ-020 key_valid SHALL never be high two consecutive cycles.
REQ-021 cnt SHALL saturate-free count only within DB_PRESS/DB_REL and SHALL never wrap.

Reset
REQ-022 On reset=1, asynchronously: state<=IDLE; cnt, cand, synchronizer flops, key_out, key_code<=0; key_valid<=0.
REQ-023 Reset mid-debounce SHALL abort with no strobe.
REQ-024 A key still held at reset release SHALL be re-debounced from scratch, with full latency per REQ-016.

Structure
REQ-025 Package keypad_pkg SHALL hold: FSM state enum, KEY_W=4, KEY_CODE_W=2, default DEBOUNCE_CYCLES.
REQ-026 Sub-module sync2 SHALL implement the per-bit 2-flop synchronizer, with async reset to 0.
REQ-027 The one-hot check and encoder SHALL be combinational functions inside keypad_debounce.

Verification (DEBOUNCE_CYCLES=4, 20 ns clock)
REQ-028 Reset, then key_raw=0001 held 12 cycles -> key_out=0001 after edge 7, key_valid high 1 cycle, key_code=0.
REQ-029 key_raw 0010 for 2 cycles, 0000 for 1, then 0010 stable -> exactly one key_valid; key_out=0010 only after 4 stable synchronized cycles; key_code=1.
REQ-030 key_raw=0101 held 20 cycles -> key_out stays 0000, key_valid never asserts.
REQ-031 From HELD 0100, key_raw=0000 for 1 cycle then 0100 -> key_out stays 0100 with no strobe; then key_raw=0000 stable -> key_out=0000 after edge 7.
REQ-032 key_raw 0001 stable, reset pulsed at cycle 4 -> all outputs 0, no strobe; with 0001 still held after reset, key_out=0001 at edge 7 after reset release.
REQ-033 HELD 0001, key_raw switched directly to 1000 -> key_out 0001 -> 0000 after edge 7 -> 1000 five edges later, one strobe, key_code=3.
